whack_a_mole: RTL and testbench

Single-player whack-a-mole game core in Tiny Tapeout top-level pinout. It does the following:
- A pseudo-random "mole" (index 0-7) lights on a 7-segment digit.
- The player presses the matching button on ui_in.
- Each hit increments an 8-bit score shown on the uio LEDs.
- Moles time out if not hit, then a blank gap precedes the next mole.

---
 rtl/whack_pkg.sv | 28 ++
 rtl/whack_button_sync.sv | 36 +++
 rtl/whack_a_mole.sv | 102 ++++++++++
 tb/tb_whack_a_mole.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Module : whack_pkg
// Brief  : Shared types and constants for the whack-a-mole game core.
// Rev    : 1.0  initial release
// ============================================================================
package whack_pkg;

   typedef enum logic [0:0] {
      GAP = 1'b0,
      UP  = 1'b1
   } state_t;

   localparam int          C_SCORE_W   = 8;
   localparam logic [15:0] C_LFSR_MASK = 16'hB400;
   localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

   // Segment codes a..g (bit0 = a); element [0] is the digit 0 pattern.
   localparam logic [7:0][6:0] C_SEG_TABLE = {
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [C_SCORE_W-1:0] sat_inc(input logic [C_SCORE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/whack_button_sync.sv
`default_nettype none
// ============================================================================
// Module : whack_button_sync
// Brief  : 8-bit two-flop synchronizer with registered rising-edge detect.
// Rev    : 1.0  initial release
// ============================================================================
module whack_button_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_btn,
   output logic [7:0] o_press
);

   logic [7:0] r_sync1;
   logic [7:0] r_sync2;
   logic [7:0] r_prev;
   logic [7:0] r_press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_press <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_press <= r_sync2 & ~r_prev;
      end
   end

   assign o_press = r_press;

endmodule : whack_button_sync
`default_nettype wire

// File: rtl/whack_a_mole.sv
`default_nettype none
// ============================================================================
// Module : whack_a_mole
// Brief  : Whack-a-mole game core, Tiny Tapeout pinout (rst_n is active-high).
// Rev    : 1.0  initial release
// ============================================================================
module whack_a_mole
   import whack_pkg::*;
#(
   parameter int          MOLE_TICKS = 25_000_000,
   parameter int          GAP_TICKS  = 5_000_000,
   parameter logic [15:0] LFSR_SEED  = C_LFSR_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic                 w_rst;
   logic [7:0]           w_press;
   state_t               r_state, w_state_nxt;
   logic [31:0]          r_cnt, w_cnt_nxt;
   logic [2:0]           r_mole, w_mole_nxt;
   logic [C_SCORE_W-1:0] r_score, w_score_nxt;
   logic [15:0]          r_lfsr;
   logic                 w_unused;

   assign w_rst    = rst_n;
   assign w_unused = &{1'b0, ena, uio_in};

   whack_button_sync u_btn (
      .clk     (clk),
      .rst     (w_rst),
      .i_btn   (ui_in),
      .o_press (w_press)
   );

   // Free-running Galois LFSR; the mole index is sampled from it on GAP exit.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? C_LFSR_MASK : 16'h0000);
      end
   end

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_state <= GAP;
         r_cnt   <= '0;
         r_mole  <= '0;
         r_score <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mole  <= w_mole_nxt;
         r_score <= w_score_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 32'd1;
      w_mole_nxt  = r_mole;
      w_score_nxt = r_score;
      case (r_state)
         GAP: begin
            if (r_cnt == 32'(GAP_TICKS - 1)) begin
               w_mole_nxt  = r_lfsr[2:0];
               w_cnt_nxt   = '0;
               w_state_nxt = UP;
            end
         end
         UP: begin
            // A hit takes priority over a timeout landing on the same cycle.
            if (w_press[r_mole]) begin
               w_score_nxt = sat_inc(r_score);
               w_cnt_nxt   = '0;
               w_state_nxt = GAP;
            end else if (r_cnt == 32'(MOLE_TICKS - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = GAP;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = GAP;
         end
      endcase
   end

   assign uo_out  = (r_state == UP) ? {1'b1, C_SEG_TABLE[r_mole]} : 8'h00;
   assign uio_out = r_score;
   assign uio_oe  = 8'hFF;

endmodule : whack_a_mole
`default_nettype wire

// File: tb/tb_whack_a_mole.sv
`default_nettype none
// ============================================================================
// Module : tb_whack_a_mole
// Brief  : Directed self-checking bench for the whack_a_mole game core.
// Rev    : 1.0  initial release
// ============================================================================
module tb_whack_a_mole;

   localparam int A_HIT       = 0;
   localparam int A_TIMEOUT   = 1;
   localparam int A_WRONG_HIT = 2;
   localparam int A_LATE_HIT  = 3;

   typedef struct {
      int         act;
      logic [7:0] exp_score;
   } round_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   whack_a_mole #(
      .MOLE_TICKS (100),
      .GAP_TICKS  (10),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] seg(input int m);
      case (m)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         default: return 7'h07;
      endcase
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [7:0] sat(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Polls until a mole appears; returns its index and the cycles waited.
   task automatic wait_mole(output int m, output int n);
      bit ok = 0;
      bit found = 0;
      m = 0;
      n = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         n++;
         if (uo_out[7]) ok = 1;
      end
      if (!ok) check("mole_appear_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 8; k++) begin
         if (!found && uo_out[6:0] == seg(k)) begin
            m = k;
            found = 1;
         end
      end
      check("mole_valid_code", {31'd0, found}, 32'd1);
   endtask

   task automatic hit(input int m, input logic [7:0] extra,
                      input logic [7:0] prev, input logic [7:0] exp);
      ui_in = 8'(1 << m) | extra;
      tick();
      ui_in = 8'h00;
      tick();
      tick();
      check("hit_pending_up", {31'd0, uo_out[7]}, 32'd1);
      check("hit_pending_score", {24'd0, uio_out}, {24'd0, prev});
      tick();
      check("hit_score", {24'd0, uio_out}, {24'd0, exp});
      check("hit_blank", {24'd0, uo_out}, 32'd0);
   endtask

   round_t      rounds [6];
   logic [15:0] lfsr_m;
   int          first_mole;
   int          m;
   int          n;
   logic [7:0]  score;

   initial begin
      rounds[0] = '{A_HIT,       8'd1};
      rounds[1] = '{A_TIMEOUT,   8'd1};
      rounds[2] = '{A_WRONG_HIT, 8'd2};
      rounds[3] = '{A_LATE_HIT,  8'd3};
      rounds[4] = '{A_TIMEOUT,   8'd3};
      rounds[5] = '{A_HIT,       8'd4};

      // First mole index: seed advanced once per cycle for the 9 cycles before GAP exit.
      lfsr_m = 16'hACE1;
      for (int i = 0; i < 9; i++) lfsr_m = lfsr_step(lfsr_m);
      first_mole = int'(lfsr_m[2:0]);

      ena    = 1'b1;
      uio_in = 8'hA5;
      ui_in  = 8'hFF;
      rst_n  = 1'b1;
      #2;
      check("reset_uo_out", {24'd0, uo_out}, 32'd0);
      check("reset_uio_oe", {24'd0, uio_oe}, 32'hFF);
      repeat (3) tick();
      check("reset_uo_out_held", {24'd0, uo_out}, 32'd0);
      check("reset_uio_out", {24'd0, uio_out}, 32'd0);
      check("reset_uio_oe_held", {24'd0, uio_oe}, 32'hFF);

      ui_in = 8'h00;
      rst_n = 1'b0;
      repeat (9) tick();
      check("first_gap_not_yet", {31'd0, uo_out[7]}, 32'd0);
      tick();
      check("first_mole_up", {31'd0, uo_out[7]}, 32'd1);
      check("first_mole_seg", {25'd0, uo_out[6:0]}, {25'd0, seg(first_mole)});
      m = first_mole;
      score = 8'd0;

      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            wait_mole(m, n);
            check("gap_len", n, 32'd10);
         end
         case (rounds[i].act)
            A_HIT: hit(m, 8'h00, score, rounds[i].exp_score);
            A_TIMEOUT: begin
               repeat (99) tick();
               check("timeout_still_up", {31'd0, uo_out[7]}, 32'd1);
               tick();
               check("timeout_blank", {24'd0, uo_out}, 32'd0);
               check("timeout_score", {24'd0, uio_out}, {24'd0, rounds[i].exp_score});
            end
            A_WRONG_HIT: begin
               ui_in = 8'(1 << ((m + 1) % 8));
               tick();
               ui_in = 8'h00;
               repeat (3) tick();
               check("wrong_mole_kept", {24'd0, uo_out}, {24'd0, 1'b1, seg(m)});
               check("wrong_score", {24'd0, uio_out}, {24'd0, score});
               hit(m, 8'h00, score, rounds[i].exp_score);
            end
            default: begin
               repeat (96) tick();
               hit(m, 8'h00, score, rounds[i].exp_score);
            end
         endcase
         score = rounds[i].exp_score;
      end

      // All buttons held from the gap through the mole window: no score.
      ui_in = 8'hFF;
      wait_mole(m, n);
      check("held_gap_len", n, 32'd10);
      repeat (10) tick();
      check("held_still_up", {31'd0, uo_out[7]}, 32'd1);
      check("held_score", {24'd0, uio_out}, {24'd0, score});
      ui_in = 8'h00;
      tick();
      hit(m, 8'h00, score, sat(score));
      score = sat(score);

      for (int i = 0; i < 251; i++) begin
         wait_mole(m, n);
         check("sat_gap_len", n, 32'd10);
         hit(m, (i % 2 == 1) ? 8'(1 << ((m + 1) % 8)) : 8'h00, score, sat(score));
         score = sat(score);
      end
      check("sat_reached", {24'd0, uio_out}, 32'hFF);
      wait_mole(m, n);
      hit(m, 8'h00, 8'hFF, 8'hFF);

      for (int i = 0; i < 3; i++) begin
         wait_mole(m, n);
         hit(m, 8'h00, 8'hFF, 8'hFF);
      end
      wait_mole(m, n);
      #2;
      rst_n = 1'b1;
      #1;
      check("midreset_score", {24'd0, uio_out}, 32'd0);
      check("midreset_uo_out", {24'd0, uo_out}, 32'd0);
      tick();
      rst_n = 1'b0;
      repeat (9) tick();
      check("rerun_gap_not_yet", {31'd0, uo_out[7]}, 32'd0);
      tick();
      check("rerun_mole_up", {31'd0, uo_out[7]}, 32'd1);
      check("rerun_mole_seg", {25'd0, uo_out[6:0]}, {25'd0, seg(first_mole)});
      check("rerun_score", {24'd0, uio_out}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_whack_a_mole
`default_nettype wire
